// File: rtl/ddr_rdisplay_mbank_ctrl_pkg.sv
// Shared types and constants for the multi-bank DDR display read controller.
package ddr_rdisplay_mbank_ctrl_pkg;

  localparam int unsigned RdLenW = 10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StReq,
    StBurst,
    StDone
  } rd_state_e;

endpackage

// File: rtl/ddr_rdisplay_mbank_ctrl_vs_edge_sync.sv
// Brings the asynchronous VGA vsync into the DDR clock domain and flags its falling edge.
module ddr_rdisplay_mbank_ctrl_vs_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic vs_fall_o
);

  logic meta_q, d0_q, d1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      d0_q   <= 1'b0;
      d1_q   <= 1'b0;
    end else begin
      meta_q <= vs_i;
      d0_q   <= meta_q;
      d1_q   <= d0_q;
    end
  end

  assign vs_fall_o = d1_q & ~d0_q;

endmodule

// File: rtl/ddr_rdisplay_mbank_ctrl.sv
// Streams one frame per vsync from a selected DDR bank into the display FIFO in fixed bursts.
module ddr_rdisplay_mbank_ctrl
  import ddr_rdisplay_mbank_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned BANK_W      = 2,
  parameter int unsigned FRAME_WORDS = 245760,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FIFO_LEN_W  = 10,
  parameter int unsigned FIFO_THRESH = 750
) (
  input  logic                  ddr_clk_i,
  input  logic                  ddr_rst_i,
  input  logic                  ddr_ready_i,
  output logic                  mem_ren_o,
  input  logic                  mem_ren_valid_i,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic [RdLenW-1:0]     rd_len_o,
  input  logic                  rd_burst_data_valid_i,
  input  logic [31:0]           rd_burst_data_i,
  output logic                  w_fifo_en_o,
  output logic [31:0]           w_fifo_data_o,
  input  logic [FIFO_LEN_W-1:0] fifo_len_i,
  input  logic                  fifo_full_flag_i,
  output logic                  fifo_clear_o,
  input  logic                  vga_vs_i,
  input  logic                  frame_wr_done_i,
  input  logic [BANK_W-1:0]     wr_bank_i,
  input  logic                  mode_follow_i,
  input  logic [BANK_W-1:0]     rd_channel_i,
  output logic [BANK_W-1:0]     cur_rd_bank_o,
  output logic                  frame_underrun_o
);

  localparam int unsigned OffW = ADDR_W - BANK_W;

  rd_state_e         state_q, state_d;
  logic              mem_ren_q, mem_ren_d;
  // One spare bit so a frame filling the whole bank can reach FRAME_WORDS without wrapping.
  logic [OffW:0]     offset_q, offset_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] last_bank_q, last_bank_d;
  logic [RdLenW-1:0] beat_cnt_q, beat_cnt_d;
  logic              discard_q, discard_d;
  logic              underrun_q, underrun_d;
  logic              seen_wr_q, seen_wr_d;
  logic              vs_fall;
  logic              issue_ok;
  logic              last_beat;

  ddr_rdisplay_mbank_ctrl_vs_edge_sync u_vs_sync (
    .clk_i     (ddr_clk_i),
    .rst_i     (ddr_rst_i),
    .vs_i      (vga_vs_i),
    .vs_fall_o (vs_fall)
  );

  assign issue_ok  = ddr_ready_i & ~fifo_full_flag_i &
                     ({1'b0, fifo_len_i} < (FIFO_LEN_W + 1)'(FIFO_THRESH));
  assign last_beat = (beat_cnt_q == RdLenW'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    mem_ren_d   = mem_ren_q;
    offset_d    = offset_q;
    bank_d      = bank_q;
    beat_cnt_d  = beat_cnt_q;
    discard_d   = discard_q;
    underrun_d  = 1'b0;
    seen_wr_d   = seen_wr_q | frame_wr_done_i;
    last_bank_d = frame_wr_done_i ? wr_bank_i : last_bank_q;
    unique case (state_q)
      StIdle: begin
        if (vs_fall && seen_wr_q) state_d = StStart;
      end
      StStart: begin
        if (mode_follow_i) bank_d = frame_wr_done_i ? wr_bank_i : last_bank_q;
        else               bank_d = rd_channel_i;
        offset_d  = '0;
        discard_d = 1'b0;
        mem_ren_d = 1'b0;
        state_d   = StReq;
      end
      StReq: begin
        if (mem_ren_q) begin
          // Request already on the bus: it must complete, so a vsync only marks the burst stale.
          if (vs_fall && !discard_q) begin
            underrun_d = 1'b1;
            discard_d  = 1'b1;
          end
          if (mem_ren_valid_i) begin
            mem_ren_d  = 1'b0;
            offset_d   = offset_q + (OffW + 1)'(BURST_LEN);
            beat_cnt_d = '0;
            state_d    = StBurst;
          end
        end else if (vs_fall) begin
          underrun_d = 1'b1;
          state_d    = StStart;
        end else if (issue_ok) begin
          mem_ren_d = 1'b1;
        end
      end
      StBurst: begin
        if (vs_fall && !discard_q) begin
          underrun_d = 1'b1;
          discard_d  = 1'b1;
        end
        if (rd_burst_data_valid_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            if (discard_q || vs_fall)                       state_d = StStart;
            else if (offset_q == (OffW + 1)'(FRAME_WORDS)) state_d = StDone;
            else                                            state_d = StReq;
          end
        end
      end
      StDone: begin
        if (vs_fall) state_d = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      state_q     <= StIdle;
      mem_ren_q   <= 1'b0;
      offset_q    <= '0;
      bank_q      <= '0;
      last_bank_q <= '0;
      beat_cnt_q  <= '0;
      discard_q   <= 1'b0;
      underrun_q  <= 1'b0;
      seen_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ren_q   <= mem_ren_d;
      offset_q    <= offset_d;
      bank_q      <= bank_d;
      last_bank_q <= last_bank_d;
      beat_cnt_q  <= beat_cnt_d;
      discard_q   <= discard_d;
      underrun_q  <= underrun_d;
      seen_wr_q   <= seen_wr_d;
    end
  end

  assign mem_ren_o        = mem_ren_q;
  assign rd_addr_o        = {bank_q, offset_q[OffW-1:0]};
  assign rd_len_o         = RdLenW'(BURST_LEN);
  assign fifo_clear_o     = (state_q == StStart);
  assign cur_rd_bank_o    = bank_q;
  assign frame_underrun_o = underrun_q;
  assign w_fifo_data_o    = rd_burst_data_i;
  assign w_fifo_en_o      = rd_burst_data_valid_i & (state_q == StBurst) & ~discard_q & ~vs_fall;

endmodule
